// File: rtl/lorenz_integrator.sv
// lorenz_integrator: fixed-point Euler solver for the Lorenz system.
// State words x/y/z are signed 12.20; one Euler step every STEP_DIV clocks
// while run is held.
// Build option: define SATURATE_EN to clamp every product, difference and
// state update to the 32-bit signed range instead of wrapping.

module lorenz_integrator #(
  parameter int FRAC_W   = 20,
  parameter int DT_SHIFT = 8,
  parameter int STEP_DIV = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] z0,
  input  logic [31:0] sigma,
  input  logic [31:0] rho,
  input  logic [31:0] beta,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic        out_valid,
  output logic        busy,
  output logic [31:0] step_count
);

  // Bit index of the top product bit kept in the 32-bit result.
  localparam int PROD_HI = FRAC_W + 31;
  localparam int CNT_W   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  // WAIT runs STEP_DIV-2 cycles, counting this value down to zero.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(STEP_DIV - 3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_div_cnt;
  logic signed [31:0] r_x, r_y, r_z;
  logic signed [31:0] r_p1, r_p2, r_p3, r_p4;
  logic [31:0]        r_step_count;
  logic               r_out_valid;

  logic signed [31:0] w_dyx, w_drz;
  logic signed [31:0] w_p1, w_p2, w_p3, w_p4;
  logic signed [31:0] w_ty, w_tz;
  logic signed [31:0] w_nx, w_ny, w_nz;

  // 32-bit signed add, clamped or wrapped depending on the build.
  function automatic logic signed [31:0] f_add(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
`ifdef SATURATE_EN
    logic signed [32:0] s;
    s = 33'(a) + 33'(b);
    if (s > $signed(33'h0_7FFF_FFFF))      return 32'sh7FFF_FFFF;
    else if (s < $signed(33'h1_8000_0000)) return 32'sh8000_0000;
    else                                   return s[31:0];
`else
    return a + b;
`endif
  endfunction

  // 32-bit signed subtract, clamped or wrapped depending on the build.
  function automatic logic signed [31:0] f_sub(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
`ifdef SATURATE_EN
    logic signed [32:0] s;
    s = 33'(a) - 33'(b);
    if (s > $signed(33'h0_7FFF_FFFF))      return 32'sh7FFF_FFFF;
    else if (s < $signed(33'h1_8000_0000)) return 32'sh8000_0000;
    else                                   return s[31:0];
`else
    return a - b;
`endif
  endfunction

  // Fixed-point multiply: full 64-bit product, keep bits [FRAC_W+31:FRAC_W].
  // When saturating, any bit above the kept window that is not a copy of
  // the sign means the true result does not fit in 32 bits.
  function automatic logic signed [31:0] f_mul(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] prod;
`ifdef SATURATE_EN
    logic signed [63:0] hi;
`endif
    prod = 64'(a) * 64'(b);
`ifdef SATURATE_EN
    hi = prod >>> PROD_HI;
    if (hi > 64'sd0)       return 32'sh7FFF_FFFF;
    else if (hi < -64'sd1) return 32'sh8000_0000;
`endif
    return 32'(prod >>> FRAC_W);
  endfunction

  // Product inputs from the current state and the live coefficients.
  always_comb begin
    w_dyx = f_sub(r_y, r_x);
    w_drz = f_sub($signed(rho), r_z);
    w_p1  = f_mul($signed(sigma), w_dyx);
    w_p2  = f_mul(r_x, w_drz);
    w_p3  = f_mul(r_x, r_y);
    w_p4  = f_mul($signed(beta), r_z);
  end

  // Euler update from the registered products; dt is an arithmetic shift.
  always_comb begin
    w_ty = f_sub(r_p2, r_y);
    w_tz = f_sub(r_p3, r_p4);
    w_nx = f_add(r_x, r_p1 >>> DT_SHIFT);
    w_ny = f_add(r_y, w_ty >>> DT_SHIFT);
    w_nz = f_add(r_z, w_tz >>> DT_SHIFT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; load overrides everything and parks the FSM in IDLE.
  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (run) w_next = S_MUL;
        S_MUL:  w_next = S_ACC;
        S_ACC:  w_next = S_WAIT;
        S_WAIT: if (r_div_cnt == '0) w_next = run ? S_MUL : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Step pacing counter, loaded in ACC and counted down through WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    r_div_cnt <= '0;
    else if (load)                                   r_div_cnt <= '0;
    else if (r_state == S_ACC)                       r_div_cnt <= DIV_LOAD;
    else if (r_state == S_WAIT && r_div_cnt != '0)   r_div_cnt <= r_div_cnt - 1'b1;
  end

  // Product registers; coefficients are only sampled here, in MUL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
      r_p4 <= '0;
    end else if (r_state == S_MUL && !load) begin
      r_p1 <= w_p1;
      r_p2 <= w_p2;
      r_p3 <= w_p3;
      r_p4 <= w_p4;
    end
  end

  // Integrator state and step counter: load restarts, ACC commits a step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_step_count <= '0;
    end else if (load) begin
      r_x          <= $signed(x0);
      r_y          <= $signed(y0);
      r_z          <= $signed(z0);
      r_step_count <= '0;
    end else if (r_state == S_ACC) begin
      r_x          <= w_nx;
      r_y          <= w_ny;
      r_z          <= w_nz;
      r_step_count <= r_step_count + 32'd1;
    end
  end

  // Valid pulse lines up with the cycle the new state becomes visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_out_valid <= 1'b0;
    else          r_out_valid <= (r_state == S_ACC) && !load;
  end

  assign x_out      = r_x;
  assign y_out      = r_y;
  assign z_out      = r_z;
  assign step_count = r_step_count;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lorenz_integrator.sv
// Testbench for lorenz_integrator: scoreboard of expected x/y/z/step_count
// pushed when a step is launched and popped on each out_valid pulse.

module tb_lorenz_integrator;

  localparam int STEP_DIV = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, run;
  logic [31:0] x0, y0, z0, sigma, rho, beta;
  logic [31:0] x_out, y_out, z_out, step_count;
  logic        out_valid, busy;

  always #5 clk = ~clk;

  lorenz_integrator #(.FRAC_W(20), .DT_SHIFT(8), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .run(run),
    .x0(x0), .y0(y0), .z0(z0), .sigma(sigma), .rho(rho), .beta(beta),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .out_valid(out_valid), .busy(busy), .step_count(step_count)
  );

  typedef struct {
    logic [31:0] x, y, z, cnt;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int failures = 0;
  int mX, mY, mZ;
  logic [31:0] mCnt;
  int cycle = 0;
  int validSeen = 0;
  int lastValidCycle = -1;
  bit checkPeriod = 1'b0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Fit a wide result into 32 bits (clamp when saturating, else wrap).
  function automatic int fit(input longint v);
`ifdef SATURATE_EN
    if (v > MAXV) return 32'h7FFF_FFFF;
    if (v < MINV) return 32'h8000_0000;
`endif
    return int'(v[31:0]);
  endfunction

  function automatic int mulq(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return fit(p >>> 20);
  endfunction

  // Advance the reference model one Euler step and queue its result.
  task automatic pushStep();
    int dyx, drz, p1, p2, p3, p4, t, u;
    exp_t e;
    dyx = fit(longint'(mY) - longint'(mX));
    drz = fit(longint'(int'(rho)) - longint'(mZ));
    p1 = mulq(int'(sigma), dyx);
    p2 = mulq(mX, drz);
    p3 = mulq(mX, mY);
    p4 = mulq(int'(beta), mZ);
    t = fit(longint'(p2) - longint'(mY));
    u = fit(longint'(p3) - longint'(p4));
    mX = fit(longint'(mX) + longint'(p1 >>> 8));
    mY = fit(longint'(mY) + longint'(t >>> 8));
    mZ = fit(longint'(mZ) + longint'(u >>> 8));
    mCnt = mCnt + 32'd1;
    e.x = mX; e.y = mY; e.z = mZ; e.cnt = mCnt;
    sbQ.push_back(e);
  endtask

  always @(posedge clk) cycle++;

  // Output monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      exp_t e;
      validSeen++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_x", x_out, e.x);
        checkOutput("sb_y", y_out, e.y);
        checkOutput("sb_z", z_out, e.z);
        checkOutput("sb_count", step_count, e.cnt);
      end
      if (checkPeriod && lastValidCycle >= 0)
        checkOutput("valid_period", cycle - lastValidCycle, STEP_DIV);
      lastValidCycle = cycle;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a load for one clock and restart the reference model.
  task automatic applyStimulus(input logic [31:0] ix, input logic [31:0] iy,
                               input logic [31:0] iz);
    x0 = ix; y0 = iy; z0 = iz;
    load = 1'b1;
    tick();
    load = 1'b0;
    mX = int'(ix); mY = int'(iy); mZ = int'(iz); mCnt = 32'd0;
  endtask

  task automatic waitValids(input int target, input int budget);
    int n = 0;
    while (validSeen < target && n < budget) begin
      tick();
      n++;
    end
    if (validSeen < target) checkOutput("valid_timeout", validSeen, target);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; run = 1'b0;
    x0 = '0; y0 = '0; z0 = '0;
    sigma = 32'h00A0_0000; rho = 32'h01C0_0000; beta = 32'h002A_AAAB;
    mX = 0; mY = 0; mZ = 0; mCnt = 32'd0;
    #12;
    checkOutput("rst_x", x_out, 32'd0);
    checkOutput("rst_y", y_out, 32'd0);
    checkOutput("rst_z", z_out, 32'd0);
    checkOutput("rst_count", step_count, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single step from (1,0,0), run dropped right after MUL entry.
    $display("[TB] single step");
    applyStimulus(32'h0010_0000, 32'd0, 32'd0);
    checkOutput("load_x", x_out, 32'h0010_0000);
    checkOutput("load_busy", {31'd0, busy}, 32'd0);
    pushStep();
    run = 1'b1;
    tick();
    checkOutput("mul_busy", {31'd0, busy}, 32'd1);
    run = 1'b0;
    tick();
    checkOutput("valid_acc", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("valid_2clk", {31'd0, out_valid}, 32'd1);
    checkOutput("step1_x", x_out, 32'h000F_6000);
    checkOutput("step1_y", y_out, 32'h0001_C000);
    checkOutput("step1_z", z_out, 32'd0);
    checkOutput("step1_count", step_count, 32'd1);
    waitIdle(2 * STEP_DIV);
    tick(3);
    checkOutput("no_extra_step", step_count, 32'd1);
    checkOutput("sb_empty1", sbQ.size(), 32'd0);

    // Run held for five steps: valid pulses exactly STEP_DIV apart.
    $display("[TB] five steps");
    applyStimulus(32'h0010_0000, 32'h0010_0000, 32'h0010_0000);
    for (int i = 0; i < 5; i++) pushStep();
    checkPeriod = 1'b1;
    lastValidCycle = -1;
    run = 1'b1;
    waitValids(validSeen + 5, 5 * STEP_DIV + 10);
    run = 1'b0;
    waitIdle(2 * STEP_DIV);
    checkPeriod = 1'b0;
    checkOutput("five_count", step_count, 32'd5);
    checkOutput("sb_empty5", sbQ.size(), 32'd0);

    // Load during WAIT with run still high: load wins.
    $display("[TB] load in WAIT");
    applyStimulus(32'h0010_0000, 32'h0004_0000, 32'hFFF0_0000);
    pushStep();
    run = 1'b1;
    waitValids(validSeen + 1, 2 * STEP_DIV);
    checkOutput("wait_busy", {31'd0, busy}, 32'd1);
    x0 = 32'h0020_0000; y0 = 32'h0008_0000; z0 = 32'h0004_0000;
    load = 1'b1;
    tick();
    checkOutput("ldw_x", x_out, 32'h0020_0000);
    checkOutput("ldw_count", step_count, 32'd0);
    checkOutput("ldw_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ldw_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("ldw_hold_busy", {31'd0, busy}, 32'd0);
    load = 1'b0;
    mX = 32'h0020_0000; mY = 32'h0008_0000; mZ = 32'h0004_0000; mCnt = 32'd0;
    pushStep();
    tick();
    checkOutput("after_load_mul", {31'd0, busy}, 32'd1);
    run = 1'b0;
    waitValids(validSeen + 1, 2 * STEP_DIV);
    waitIdle(2 * STEP_DIV);
    checkOutput("sb_empty_ld", sbQ.size(), 32'd0);

    // Load during MUL discards the step entirely.
    $display("[TB] load in MUL");
    run = 1'b1;
    tick();
    checkOutput("mul2_busy", {31'd0, busy}, 32'd1);
    x0 = 32'h0030_0000; y0 = 32'h0001_0000; z0 = 32'h0002_0000;
    load = 1'b1;
    run = 1'b0;
    tick();
    load = 1'b0;
    tick(4);
    checkOutput("ldm_count", step_count, 32'd0);
    checkOutput("ldm_x", x_out, 32'h0030_0000);
    checkOutput("ldm_busy", {31'd0, busy}, 32'd0);

    // Overflowing x*y: clamps when saturating, wraps otherwise.
    $display("[TB] overflow step");
    applyStimulus(32'h7FF0_0000, 32'h7FF0_0000, 32'd0);
    pushStep();
    run = 1'b1;
    tick();
    run = 1'b0;
    waitValids(validSeen + 1, 2 * STEP_DIV);
`ifdef SATURATE_EN
    checkOutput("ovf_z", z_out, 32'h007F_FFFF);
`else
    checkOutput("ovf_z", z_out, 32'h0000_1000);
`endif
    waitIdle(2 * STEP_DIV);

    // Asynchronous reset in the middle of WAIT.
    $display("[TB] reset mid-step");
    applyStimulus(32'h0010_0000, 32'd0, 32'd0);
    pushStep();
    run = 1'b1;
    waitValids(validSeen + 1, 2 * STEP_DIV);
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_x", x_out, 32'd0);
    checkOutput("arst_y", y_out, 32'd0);
    checkOutput("arst_z", z_out, 32'd0);
    checkOutput("arst_count", step_count, 32'd0);
    checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    run = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    checkOutput("sb_empty_end", sbQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
